// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, inverse S-box table and GF(2^8) helpers
package aes_pkg;

    localparam int BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x modulo 0x11B
    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product by shift-and-add over the bits of b
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_mul2(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               final_round,
    output logic [BLOCK_W-1:0] state_out
);

    // Byte i of the state is bits [127-8i -: 8]; byte 4c+r is row r, column c.
    logic [7:0] s_sub [16];
    logic [7:0] s_ark [16];
    logic [7:0] s_mix [16];
    logic [7:0] a0, a1, a2, a3;

    // InvShiftRows folded into the S-box read address, then InvSubBytes and AddRoundKey
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s_sub[4*c+r] = INV_SBOX[state_in[BLOCK_W-1-8*(4*((c-r+4)%4)+r) -: 8]];
            end
        end
        for (int i = 0; i < 16; i++) begin
            s_ark[i] = s_sub[i] ^ round_key[BLOCK_W-1-8*i -: 8];
        end
    end

    // InvMixColumns on each column with coefficients {0e,0b,0d,09}
    always_comb begin
        a0 = 8'h00;
        a1 = 8'h00;
        a2 = 8'h00;
        a3 = 8'h00;
        for (int c = 0; c < 4; c++) begin
            a0 = s_ark[4*c];
            a1 = s_ark[4*c+1];
            a2 = s_ark[4*c+2];
            a3 = s_ark[4*c+3];
            s_mix[4*c]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            s_mix[4*c+1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            s_mix[4*c+2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            s_mix[4*c+3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    end

    // Repack; the last round skips InvMixColumns
    always_comb begin
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            state_out[BLOCK_W-1-8*i -: 8] = final_round ? s_ark[i] : s_mix[i];
        end
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES inverse cipher, one round per clock
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [127:0]                 data_in,
    input  logic [NUM_ROUNDS:0][127:0]   key,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [127:0]                 data_out
);

    localparam int RW = $clog2(NUM_ROUNDS);

    fsm_t               fsm;
    logic [RW-1:0]      rnd;
    logic [BLOCK_W-1:0] st;
    logic [BLOCK_W-1:0] round_out;
    logic               final_round;

    assign final_round = (rnd == '0);
    // Ready only in IDLE and held low while reset is asserted
    assign in_ready    = (fsm == IDLE) && !rst;

    aes_inv_round u_round (
        .state_in    (st),
        .round_key   (key[rnd]),
        .final_round (final_round),
        .state_out   (round_out)
    );

    // Control FSM, round counter, state register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            rnd       <= '0;
            st        <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st  <= data_in ^ key[NUM_ROUNDS];
                        rnd <= RW'(NUM_ROUNDS - 1);
                        fsm <= ROUND;
                    end
                end
                ROUND: begin
                    st <= round_out;
                    if (final_round) begin
                        data_out  <= round_out;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        rnd <= rnd - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb/tb_aes_decrypt_iter.sv - self-checking bench for aes_decrypt_iter
module tb_aes_decrypt_iter;

    localparam int NR = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [127:0]      data_in;
    logic [NR:0][127:0] key;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      data_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sbox [256];

    localparam logic [255:0] C3_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C3_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] TM_KEY  = 256'h1212121269696969343434343434343456565656565656567878787878787878;
    localparam logic [127:0] TM_CT   = 128'ha52422117500d3e82c96d0dafc491931;
    localparam logic [127:0] TM_PT   = 128'h1212121234343434ababababcdcdcdcd;

    always #5 clk = ~clk;

    aes_decrypt_iter #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [NR:0][127:0] expand_key(input logic [255:0] k);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [NR:0][127:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [NR:0][127:0] rk);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a [4];
        logic [127:0] v;
        v = pt ^ rk[0];
        for (int rd = 1; rd <= NR; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[v[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = s[4*((c+r)%4)+r];
            if (rd != NR) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = t[4*c+r];
                    t[4*c]   = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
                    t[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
                    t[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
                    t[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
            v = v ^ rk[rd];
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [127:0] ct);
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        n_tests++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL start_block: in_ready=%0b required 1 within 50 cycles", in_ready);
        end
        data_in  = ct;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        n_tests++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL wait_valid: out_valid=%0b required 1 within 200 cycles", out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_tests++;
        if (data_out !== 128'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic run_vector(input string name, input logic [255:0] k,
                              input logic [127:0] ct, input logic [127:0] pt);
        int lat;
        key       = expand_key(k);
        out_ready = 1'b1;
        start_block(ct);
        wait_valid(lat);
        n_tests++;
        if (lat !== NR) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, NR); end
        n_tests++;
        if (data_out !== pt) begin n_fail++; $display("FAIL %s_data: got %h want %h", name, data_out, pt); end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%0b in_ready=%0b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_c3();
        run_vector("c3", C3_KEY, C3_CT, C3_PT);
    endtask

    task automatic test_team_vector();
        run_vector("team", TM_KEY, TM_CT, TM_PT);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        key       = expand_key(C3_KEY);
        out_ready = 1'b0;
        start_block(C3_CT);
        wait_valid(lat);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (data_out !== C3_PT || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cycle %0d: data_out=%h out_valid=%0b in_ready=%0b want %h/1/0",
                         i, data_out, out_valid, in_ready, C3_PT);
            end
            tick();
        end
        n_tests++;
        if (bad != 0) n_fail++;
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int extra;
        key       = expand_key(C3_KEY);
        out_ready = 1'b1;
        start_block(C3_CT);
        tick();
        tick();
        tick();
        data_in  = TM_CT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        n_tests++;
        if (data_out !== C3_PT) begin n_fail++; $display("FAIL busy_data: got %h want %h", data_out, C3_PT); end
        tick();
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) extra++;
            tick();
        end
        n_tests++;
        if (extra != 0) begin n_fail++; $display("FAIL busy_extra_output: got %0d valid cycles want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int stray;
        key       = expand_key(C3_KEY);
        out_ready = 1'b1;
        start_block(C3_CT);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || data_out !== 128'h0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: out_valid=%0b data_out=%h in_ready=%0b want 0/0/0",
                     out_valid, data_out, in_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %0b want 1", in_ready); end
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) stray++;
            tick();
        end
        n_tests++;
        if (stray != 0) begin n_fail++; $display("FAIL midreset_stray_output: got %0d want 0", stray); end
        run_vector("post_reset_c3", C3_KEY, C3_CT, C3_PT);
    endtask

    task automatic test_back_to_back();
        logic [127:0] expq [$];
        logic [255:0] k;
        logic [127:0] pt;
        logic [127:0] got;
        logic [127:0] want;
        logic [NR:0][127:0] rk;
        bit   seen;
        int   bad;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        rk  = expand_key(k);
        key = rk;
        bad = 0;
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < 4; i++) pt[32*i +: 32] = $urandom;
            expq.push_back(pt);
            out_ready = 1'($urandom_range(0, 1));
            start_block(aes_enc(pt, rk));
            seen = 1'b0;
            got  = '0;
            for (int c = 0; c < 300 && !seen; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    got  = data_out;
                    seen = 1'b1;
                end
                tick();
            end
            want = expq.pop_front();
            if (!seen || got !== want) begin
                bad++;
                $display("FAIL b2b block %0d: seen=%0b got %h want %h", b, seen, got, want);
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        init_sbox();
        key       = expand_key(C3_KEY);
        test_reset();
        test_c3();
        test_team_vector();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
- Iterative AES inverse cipher, the decrypt counterpart of the combinational AESEncrypt path.
- Executes one inverse round per clock and consumes the round-key array produced by ExpandKey (NUM_ROUNDS+1 entries of 128 bits).
- Uses a valid/ready handshake on the input and output sides, so it can sit between a ciphertext source and a plaintext sink with backpressure.

Parameters:
- NUM_ROUNDS, default 14: AES round count. Legal values are 10, 12 and 14, for AES-128/192/256.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ciphertext on data_in is valid
- in_ready  output  1  block can accept a ciphertext
- data_in  input  128  ciphertext; bits [127:120] are state byte 0 (FIPS-197 order)
- key  input  [NUM_ROUNDS:0][127:0]  expanded round keys; key[0] is the first round key
- out_valid  output  1  plaintext on data_out is valid
- out_ready  input  1  sink accepts data_out
- data_out  output  128  plaintext, same byte order as data_in

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE, in_ready=0 during the reset cycle, then 1 in IDLE
  - out_valid=0, data_out=0, round counter=0, state register=0
- Reset wins over every other event. Reset mid-operation aborts the block and discards it; no partial output appears.
- FSM states are IDLE, ROUND and DONE.
- IDLE:
  - in_ready=1.
  - On the accepting edge (in_valid & in_ready): state register <= data_in ^ key[NUM_ROUNDS]; rnd <= NUM_ROUNDS-1; go to ROUND.
- ROUND:
  - in_ready=0. Each edge applies one inverse round.
  - For rnd>0: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ key[rnd]); rnd decrements.
  - For rnd==0 (final round): state <= InvSubBytes(InvShiftRows(state)) ^ key[0], with no InvMixColumns; data_out <= result; out_valid <= 1; go to DONE.
- DONE:
  - out_valid=1, and data_out is held stable until out_ready=1.
  - On the edge with out_valid & out_ready: out_valid <= 0; go to IDLE. in_ready is high in the next cycle, so no same-cycle reaccept.
- Latency: out_valid is first high after the NUM_ROUNDS-th rising edge following the accepting edge (14 edges for AES-256). Throughput is one block per NUM_ROUNDS+2 cycles when out_ready is held high.
- key is not registered. The source must hold key stable from the accepting edge until out_valid rises; a key change in that window gives undefined data_out but FSM timing is unaffected.
- in_valid while not IDLE is ignored; the data is not captured.
- out_ready while not in DONE has no effect.
- All byte arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns uses coefficients {0e,0b,0d,09}.
- Inverse S-box lookups are combinational within the round; there are no multicycle paths.

Decomposition:
- aes_pkg holds:
  - the INV_SBOX[256] constant
  - the gf_mul2 / gf_mul functions
  - the state_t typedef (logic [127:0])
  - a fsm_t enum {IDLE, ROUND, DONE}
  - the BLOCK_W=128 constant
- One combinational sub-module, aes_inv_round, takes (state_in, round_key, final_round) and returns state_out. It implements InvShiftRows, InvSubBytes, AddRoundKey and conditional InvMixColumns. The top module holds only the FSM, counter and registers.

Test Plan:
- FIPS-197 C.3 vector: ExpandKey with key=000102…1e1f, data_in=8ea2b7ca516745bfeafc49904b496089, out_ready=1 -> out_valid high 14 edges after accept, data_out=00112233445566778899aabbccddeeff.
- Team AES-256 vector: key=1212121269696969343434343434343456565656565656567878787878787878, data_in=a52422117500d3e82c96d0dafc491931 -> data_out=1212121234343434ababababcdcdcdcd.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> data_out stable, out_valid=1, in_ready=0 throughout; release -> out_valid drops the next edge, in_ready=1 one cycle later.
- Busy ignore: pulse in_valid with a different ciphertext during ROUND -> first result is unchanged and no second output appears.
- Reset mid-operation: assert rst at round 7 -> next cycle out_valid=0, data_out=0. After release, in_ready=1 and a fresh C.3 decrypt completes correctly.
- Back-to-back: 100 random plaintexts are encrypted with AESEncrypt and fed to this block with random out_ready stalls -> every data_out equals the original plaintext, in order.
